tspp_pipeline_ctrl: RTL and testbench
=====================================

// Module: tspp_pipeline_ctrl
// PURPOSE
//  Sequencing controller for the two-stage (fetch/execute) pipeline. It owns the fetch PC
//  and drives the imem read request. It decides every cycle whether the fetch->execute
//  pipeline register loads, holds or is flushed to a bubble.
//  Sits between the fetch stage, the execute stage's branch/jump, memory-wait and halt
//  signals, and the instruction memory port.
// PARAMETERS
//  RESET_PC   32'h0000_0200  fetch PC loaded on reset
// PORTS
//  CLK             in   1   clock; all state updates on rising edge
//  RST             in   1   reset, synchronous, active-high
//  imem_wait       in   1   current imem read not yet complete
//  ex_mem_op       in   1   execute holds a load/store
//  dmem_wait       in   1   data memory access not yet complete
//  brj_taken       in   1   execute resolved a taken branch/jump this cycle
//  brj_addr        in   32  redirect target; bits[1:0] ignored (treated as 0)
//  halt_req        in   1   execute decoded a halt
//  imem_ren        out  1   instruction read request
//  pc              out  32  fetch PC / imem address
//  fetch_ex_en     out  1   load fetch_ex_reg with fetched instruction
//  fetch_ex_flush  out  1   load fetch_ex_reg with bubble (valid=0)
//  halted          out  1   core halted
//  stall_cycles    out  32  perf counter (see CONFIGURATION)
//  flush_count     out  32  perf counter (see CONFIGURATION)
// BEHAVIOUR
//  - ex_stall = ex_mem_op & dmem_wait. Outputs are combinational from state and inputs.
//    pc and state are registered.
//  - fetch_ex_en and fetch_ex_flush are never both 1. While ex_stall=1 both are 0 and the
//    register holds.
//  - RST (sync): state=RUN, pc=RESET_PC, target=0, counters=0.
//    In the RST cycle: imem_ren=0, fetch_ex_en=0, fetch_ex_flush=1, halted=0.
//  - States: RUN, HOLD, DRAIN, HALTED. Conditions are tested in the order listed;
//    the first match wins.
//  - RUN: imem_ren=1.
//    * ex_stall & imem_wait: stay in RUN; hold pc.
//    * ex_stall & !imem_wait: go to HOLD. The fetch stage keeps the completed instruction.
//    * halt_req: fetch_ex_flush=1; go to HALTED.
//    * brj_taken & imem_wait: fetch_ex_flush=1; target<=brj_addr&~3; go to DRAIN.
//    * brj_taken & !imem_wait: fetch_ex_flush=1; pc<=brj_addr&~3; stay in RUN.
//    * imem_wait: fetch_ex_flush=1 (bubble); hold pc.
//    * otherwise: fetch_ex_en=1; pc<=pc+4.
//  - HOLD: imem_ren=0, pc held.
//    * ex_stall: stay in HOLD.
//    * halt_req: fetch_ex_flush=1; go to HALTED.
//    * brj_taken: fetch_ex_flush=1; pc<=brj_addr&~3; go to RUN.
//    * otherwise: fetch_ex_en=1; pc<=pc+4; go to RUN.
//  - DRAIN: the wrong-path read is in flight.
//    * imem_ren=1 and pc=old address until imem_wait=0; fetch_ex_flush=1 every cycle.
//    * On the cycle imem_wait=0: discard the response; pc<=target; go to RUN.
//    * brj_taken/halt_req are ignored here; execute holds a bubble.
//  - HALTED: imem_ren=0, fetch_ex_flush=1, halted=1. Only RST exits.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  - Latency: a redirect with no imem wait puts the target on pc the next cycle, with
//    exactly one bubble.
//  - RST in any state, including mid-DRAIN: the abandoned imem read is dropped.
//    The next cycle starts RUN at RESET_PC.
// CONFIGURATION
//  - TSPP_PIPE_CTRL_PERF_EN defined: stall_cycles +1 on each non-reset cycle with
//    fetch_ex_en=0 and state!=HALTED.
//    flush_count +1 on each accepted redirect (RUN/HOLD brj_taken branch taken).
//    Both counters saturate at 32'hFFFF_FFFF and clear on RST.
//  - Macro not defined: no counter registers; stall_cycles and flush_count tied to 0.
//    The port list is unchanged.
// TESTING
//  1 Reset, imem_wait=0 for 4 cycles -> pc 0x200,0x204,0x208,0x20C; fetch_ex_en=1 each
//    cycle after RST.
//  2 RUN at pc=0x300, brj_taken=1, brj_addr=0x1003, imem_wait=0 -> flush=1;
//    next cycle pc=0x1000.
//  3 brj_taken with imem_wait=1 held 3 more cycles, brj_addr=0x400 -> DRAIN.
//    pc stays old and flush=1 for 3 cycles; then pc=0x400.
//  4 ex_mem_op=1, dmem_wait=1 for 5 cycles, imem done -> HOLD, imem_ren=0, en/flush=0.
//    On release fetch_ex_en=1, pc+4. With PERF_EN, stall_cycles=5.
//  5 halt_req=1 in RUN -> flush=1, halted=1 next cycle, imem_ren=0.
//    Stays halted for 10 cycles; RST -> pc=0x200, halted=0.
//  6 pc=0xFFFF_FFFC, no stalls -> next pc=0x0000_0000.
//    RST asserted mid-DRAIN -> RUN at 0x200, old response ignored.

Source files
------------

// File: rtl/tspp_pipeline_ctrl.sv
// Fetch/execute sequencing controller: owns the fetch PC, the imem read request and the
// fetch->execute register control. Optional perf counters under TSPP_PIPE_CTRL_PERF_EN.
module tspp_pipeline_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imem_wait,
    input  logic        ex_mem_op,
    input  logic        dmem_wait,
    input  logic        brj_taken,
    input  logic [31:0] brj_addr,
    input  logic        halt_req,
    output logic        imem_ren,
    output logic [31:0] pc,
    output logic        fetch_ex_en,
    output logic        fetch_ex_flush,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] target_r;
    logic [31:0] target_nxt_s;
    logic        ex_stall_s;
    logic [31:0] brj_aligned_s;
    logic        imem_ren_s;
    logic        fetch_ex_en_s;
    logic        fetch_ex_flush_s;
    logic        halted_s;

    assign ex_stall_s    = ex_mem_op & dmem_wait;
    assign brj_aligned_s = {brj_addr[31:2], 2'b00};

    // Control decode: outputs and next state/pc/target from current state and inputs
    always_comb begin
        imem_ren_s       = 1'b0;
        fetch_ex_en_s    = 1'b0;
        fetch_ex_flush_s = 1'b0;
        halted_s         = 1'b0;
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        target_nxt_s     = target_r;
        if (RST) begin
            fetch_ex_flush_s = 1'b1;
            state_nxt_s      = ST_RUN;
            pc_nxt_s         = RESET_PC;
            target_nxt_s     = 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    imem_ren_s = 1'b1;
                    if (ex_stall_s && imem_wait) begin
                        state_nxt_s = ST_RUN;
                    end else if (ex_stall_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (halt_req) begin
                        fetch_ex_flush_s = 1'b1;
                        state_nxt_s      = ST_HALTED;
                    end else if (brj_taken && imem_wait) begin
                        fetch_ex_flush_s = 1'b1;
                        target_nxt_s     = brj_aligned_s;
                        state_nxt_s      = ST_DRAIN;
                    end else if (brj_taken) begin
                        fetch_ex_flush_s = 1'b1;
                        pc_nxt_s         = brj_aligned_s;
                    end else if (imem_wait) begin
                        fetch_ex_flush_s = 1'b1;
                    end else begin
                        fetch_ex_en_s = 1'b1;
                        pc_nxt_s      = pc_r + 32'd4;
                    end
                end
                ST_HOLD: begin
                    // Fetch stage already holds the completed instruction; no new read.
                    if (ex_stall_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (halt_req) begin
                        fetch_ex_flush_s = 1'b1;
                        state_nxt_s      = ST_HALTED;
                    end else if (brj_taken) begin
                        fetch_ex_flush_s = 1'b1;
                        pc_nxt_s         = brj_aligned_s;
                        state_nxt_s      = ST_RUN;
                    end else begin
                        fetch_ex_en_s = 1'b1;
                        pc_nxt_s      = pc_r + 32'd4;
                        state_nxt_s   = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    imem_ren_s       = 1'b1;
                    fetch_ex_flush_s = 1'b1;
                    if (!imem_wait) begin
                        pc_nxt_s    = target_r;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_HALTED: begin
                    fetch_ex_flush_s = 1'b1;
                    halted_s         = 1'b1;
                end
                default: begin
                    fetch_ex_flush_s = 1'b1;
                    state_nxt_s      = ST_RUN;
                    pc_nxt_s         = RESET_PC;
                end
            endcase
        end
    end

    // State, pc and redirect target registers (reset values come through the decode)
    always_ff @(posedge CLK) begin
        state_r  <= state_nxt_s;
        pc_r     <= pc_nxt_s;
        target_r <= target_nxt_s;
    end

    assign imem_ren       = imem_ren_s;
    assign pc             = pc_r;
    assign fetch_ex_en    = fetch_ex_en_s;
    assign fetch_ex_flush = fetch_ex_flush_s;
    assign halted         = halted_s;

`ifdef TSPP_PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        redirect_s;
    logic        stall_evt_s;

    assign redirect_s  = !RST && !ex_stall_s && !halt_req && brj_taken &&
                         ((state_r == ST_RUN) || (state_r == ST_HOLD));
    assign stall_evt_s = !RST && !fetch_ex_en_s && (state_r != ST_HALTED);

    // Saturating perf counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_tspp_pipeline_ctrl.sv
// Self-checking bench for tspp_pipeline_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all outputs compared every cycle against a behavioural model.
module tb_tspp_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST, imem_wait, ex_mem_op, dmem_wait, brj_taken, halt_req;
    logic [31:0] brj_addr;
    logic        imem_ren, fetch_ex_en, fetch_ex_flush, halted;
    logic [31:0] pc, stall_cycles, flush_count;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef TSPP_PIPE_CTRL_PERF_EN
    bit perf = 1'b1;
`else
    bit perf = 1'b0;
`endif

    tspp_pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .imem_wait(imem_wait), .ex_mem_op(ex_mem_op),
        .dmem_wait(dmem_wait), .brj_taken(brj_taken), .brj_addr(brj_addr),
        .halt_req(halt_req), .imem_ren(imem_ren), .pc(pc), .fetch_ex_en(fetch_ex_en),
        .fetch_ex_flush(fetch_ex_flush), .halted(halted), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the pipeline is doing, as flags plus plain counters
    bit          m_valid = 1'b0;
    bit          m_halted, m_hold, m_drain;
    logic [31:0] m_pc, m_tgt;
    longint      m_stall, m_flush;

    function automatic void model_out(output bit ren, output bit en, output bit fl,
                                      output bit hl);
        bit st;
        st  = ex_mem_op & dmem_wait;
        ren = 1'b0; en = 1'b0; fl = 1'b0; hl = 1'b0;
        if (RST) fl = 1'b1;
        else if (m_halted) begin fl = 1'b1; hl = 1'b1; end
        else if (m_drain) begin ren = 1'b1; fl = 1'b1; end
        else if (m_hold) begin
            if (!st) begin
                if (halt_req || brj_taken) fl = 1'b1;
                else en = 1'b1;
            end
        end else begin
            ren = 1'b1;
            if (!st) begin
                if (halt_req || brj_taken || imem_wait) fl = 1'b1;
                else en = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    always @(posedge CLK) begin
        bit ren, en, fl, hl, st;
        model_out(ren, en, fl, hl);
        st = ex_mem_op & dmem_wait;
        if (RST) begin
            m_valid = 1'b1; m_halted = 1'b0; m_hold = 1'b0; m_drain = 1'b0;
            m_pc = 32'h200; m_tgt = 32'h0; m_stall = 0; m_flush = 0;
        end else begin
            if (!en && !m_halted) m_stall++;
            if (m_halted) begin
                m_halted = 1'b1;
            end else if (m_drain) begin
                if (!imem_wait) begin m_pc = m_tgt; m_drain = 1'b0; end
            end else if (st) begin
                if (!m_hold && !imem_wait) m_hold = 1'b1;
            end else begin
                m_hold = 1'b0;
                if (halt_req) m_halted = 1'b1;
                else if (brj_taken) begin
                    m_flush++;
                    if (imem_wait && !m_hold && ren) begin
                        m_tgt = brj_addr & ~32'd3; m_drain = 1'b1;
                    end else m_pc = brj_addr & ~32'd3;
                end else if (en) m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge CLK) begin
        bit ren, en, fl, hl;
        model_out(ren, en, fl, hl);
        chk("imem_ren", 32'(imem_ren), 32'(ren));
        chk("fetch_ex_en", 32'(fetch_ex_en), 32'(en));
        chk("fetch_ex_flush", 32'(fetch_ex_flush), 32'(fl));
        chk("halted", 32'(halted), 32'(hl));
        if (m_valid) begin
            chk("pc", pc, m_pc);
            chk("stall_cycles", stall_cycles, perf ? sat(m_stall) : 32'd0);
            chk("flush_count", flush_count, perf ? sat(m_flush) : 32'd0);
        end
    end

    task automatic drive(input bit rst, input bit iw, input bit mo, input bit dw,
                         input bit bt, input logic [31:0] ba, input bit hr);
        @(posedge CLK);
        #1;
        RST = rst; imem_wait = iw; ex_mem_op = mo; dmem_wait = dw;
        brj_taken = bt; brj_addr = ba; halt_req = hr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        RST = 1'b1; imem_wait = 1'b0; ex_mem_op = 1'b0; dmem_wait = 1'b0;
        brj_taken = 1'b0; brj_addr = 32'h0; halt_req = 1'b0;
        @(negedge CLK);
        chk("rst_flush", 32'(fetch_ex_flush), 32'd1);
        chk("rst_ren", 32'(imem_ren), 32'd0);

        // Sequential fetch after reset
        for (int i = 0; i < 4; i++) begin
            idle();
            @(negedge CLK);
            chk("seq_pc", pc, 32'h200 + 32'(4 * i));
            chk("seq_en", 32'(fetch_ex_en), 32'd1);
        end

        // Redirect with no imem wait: one bubble, target next cycle
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1003, 1'b0);
        @(negedge CLK);
        chk("br_pc300", pc, 32'h300);
        chk("br_flush", 32'(fetch_ex_flush), 32'd1);

        // Redirect while imem busy -> drain; branch/halt ignored while draining
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        @(negedge CLK);
        chk("br_pc1000", pc, 32'h1000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b1);
        @(negedge CLK);
        chk("drain_pc", pc, 32'h1000);
        chk("drain_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, (i == 0), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge CLK);
            chk("drain_pc_old", pc, 32'h1000);
            chk("drain_flush", 32'(fetch_ex_flush), 32'd1);
        end
        idle();
        @(negedge CLK);
        chk("drain_target", pc, 32'h400);

        // Execute stall with completed fetch -> hold
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h700, 1'b0);
            @(negedge CLK);
            chk("hold_ren", 32'(imem_ren), (i == 0) ? 32'd1 : 32'd0);
            chk("hold_en", 32'(fetch_ex_en), 32'd0);
            chk("hold_flush", 32'(fetch_ex_flush), 32'd0);
        end
        idle();
        @(negedge CLK);
        chk("hold_release_en", 32'(fetch_ex_en), 32'd1);
        chk("hold_stalls", stall_cycles, perf ? 32'd5 : 32'd0);
        idle();
        @(negedge CLK);
        chk("hold_next_pc", pc, 32'h204);

        // Halt and recovery
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge CLK);
        chk("halt_flush", 32'(fetch_ex_flush), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, (i == 3), 32'h900, 1'b0);
            @(negedge CLK);
            chk("halted", 32'(halted), 32'd1);
            chk("halted_ren", 32'(imem_ren), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        chk("halt_rst", 32'(halted), 32'd0);
        idle();
        @(negedge CLK);
        chk("halt_rst_pc", pc, 32'h200);

        // PC wrap, then reset in the middle of a drain
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
        @(negedge CLK);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        idle();
        @(negedge CLK);
        chk("wrap_pc", pc, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h800, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        chk("drain_rst_ren", 32'(imem_ren), 32'd0);
        idle();
        @(negedge CLK);
        chk("drain_rst_pc", pc, 32'h200);
        chk("drain_rst_en", 32'(fetch_ex_en), 32'd1);
        idle();
        @(negedge CLK);
        chk("drain_rst_next", pc, 32'h204);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 79) == 0);
        end
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
